dmem_lsu_initiator: RTL and testbench

//  Initiator side of the word-wide dmem done-handshake: turns core load/store requests
//  (byte/half/word, signed/unsigned) into single-cycle dmem_read/dmem_write pulses.
//  Sub-word stores use read-modify-write. Sits between the LSU issue stage and the dmem.
//  One request in flight; result returned on a valid/ready response channel.

---
 rtl/dmem_lsu_initiator.sv | 176 +++++++++++++++++
 tb/tb_dmem_lsu_initiator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_initiator.sv
// dmem_lsu_initiator: byte/half/word load-store initiator for the word-wide done-handshake dmem.
// Optional done watchdog is compiled in with `define DMEM_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | ready for a new request
//   RD_ISSUE | one-cycle dmem_read_o pulse
//   RD_WAIT  | waiting for read done (load result or RMW merge)
//   WR_ISSUE | one-cycle dmem_write_o pulse
//   WR_WAIT  | waiting for write done
//   RESP     | response held until rsp_ready_i
module dmem_lsu_initiator #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_store_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_signed_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_data_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_data_o,
  output logic [1:0]       rsp_err_o,
  output logic             dmem_read_o,
  output logic             dmem_write_o,
  output logic [31:0]      dmem_addr_o,
  output logic [31:0]      dmem_data_o,
  input  logic [31:0]      dmem_rd_data_i,
  input  logic             dmem_done_i
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic             store_q, signed_q;
  logic [1:0]       size_q, err_q;
  logic [31:0]      addr_q, wbuf_q, rsp_data_q;
  logic [TAG_W-1:0] tag_q;
  logic             misaligned, in_wait, timeout_hit;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_val, merged;

  assign misaligned = (req_size_i == 2'd1) ? req_addr_i[0]
                    : (req_size_i != 2'd0) && (req_addr_i[1:0] != 2'b00);
  assign in_wait    = (state == RD_WAIT) || (state == WR_WAIT);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                      wait_cnt <= '0;
    else if (state == RD_ISSUE || state == WR_ISSUE)  wait_cnt <= '0;
    else if (in_wait)                                 wait_cnt <= wait_cnt + 1'b1;
  end

  // A done arriving in the final wait cycle still wins over the watchdog.
  assign timeout_hit = in_wait && !dmem_done_i && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    lane_b = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_b = dmem_rd_data_i[7:0];
      2'd1:    lane_b = dmem_rd_data_i[15:8];
      2'd2:    lane_b = dmem_rd_data_i[23:16];
      default: lane_b = dmem_rd_data_i[31:24];
    endcase
    lane_h = addr_q[1] ? dmem_rd_data_i[31:16] : dmem_rd_data_i[15:0];

    case (size_q)
      2'd0:    load_val = signed_q ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      2'd1:    load_val = signed_q ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default: load_val = dmem_rd_data_i;
    endcase

    // Store data sits right-aligned in wbuf_q until the merge overwrites it.
    merged = dmem_rd_data_i;
    if (size_q == 2'd0) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wbuf_q[7:0];
        2'd1:    merged[15:8]  = wbuf_q[7:0];
        2'd2:    merged[23:16] = wbuf_q[7:0];
        default: merged[31:24] = wbuf_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wbuf_q[15:0];
    end else begin
      merged[15:0] = wbuf_q[15:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (misaligned)                        state_nxt = RESP;
          else if (req_store_i && req_size_i[1]) state_nxt = WR_ISSUE;
          else                                   state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (dmem_done_i)      state_nxt = store_q ? WR_ISSUE : RESP;
        else if (timeout_hit) state_nxt = RESP;
      end
      WR_ISSUE: state_nxt = WR_WAIT;
      WR_WAIT:  if (dmem_done_i || timeout_hit) state_nxt = RESP;
      RESP:     if (rsp_ready_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'd0;
      err_q      <= 2'd0;
      addr_q     <= 32'h0;
      wbuf_q     <= 32'h0;
      rsp_data_q <= 32'h0;
      tag_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            store_q    <= req_store_i;
            signed_q   <= req_signed_i;
            size_q     <= req_size_i;
            addr_q     <= req_addr_i;
            wbuf_q     <= req_data_i;
            tag_q      <= req_tag_i;
            rsp_data_q <= 32'h0;
            err_q      <= misaligned ? 2'd1 : 2'd0;
          end
        end
        RD_WAIT: begin
          if (dmem_done_i) begin
            if (store_q) wbuf_q     <= merged;
            else         rsp_data_q <= load_val;
          end else if (timeout_hit) begin
            err_q <= 2'd2;
          end
        end
        WR_WAIT: if (timeout_hit) err_q <= 2'd2;
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign rsp_valid_o  = (state == RESP);
  assign rsp_tag_o    = rsp_valid_o ? tag_q : '0;
  assign rsp_data_o   = rsp_valid_o ? rsp_data_q : 32'h0;
  assign rsp_err_o    = rsp_valid_o ? err_q : 2'd0;
  assign dmem_read_o  = (state == RD_ISSUE);
  assign dmem_write_o = (state == WR_ISSUE);
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_data_o  = wbuf_q;

endmodule

// File: tb/tb_dmem_lsu_initiator.sv
// Self-checking bench for dmem_lsu_initiator: vector table plus hand sequences,
// with a behavioural dmem and a response scoreboard.
`timescale 1ns/1ps
module tb_dmem_lsu_initiator;
  localparam int TAG_W = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             req_valid_i, req_ready_o, req_store_i, req_signed_i;
  logic [1:0]       req_size_i;
  logic [31:0]      req_addr_i, req_data_i;
  logic [TAG_W-1:0] req_tag_i, rsp_tag_o;
  logic             rsp_valid_o, rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic [1:0]       rsp_err_o;
  logic             dmem_read_o, dmem_write_o, dmem_done_i;
  logic [31:0]      dmem_addr_o, dmem_data_o, dmem_rd_data_i;

  always #5 clk_i = ~clk_i;

  dmem_lsu_initiator #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_tag_o(rsp_tag_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o), .dmem_addr_o(dmem_addr_o),
    .dmem_data_o(dmem_data_o), .dmem_rd_data_i(dmem_rd_data_i), .dmem_done_i(dmem_done_i)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic [1:0]       err;
  } exp_t;

  typedef struct {
    logic        st;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    logic [31:0] exp_mem;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[17];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [0:255];
  int          n_rd, n_wr;
  int          dmem_lat = 1;
  bit          mdl_pend, mdl_wr;
  int          mdl_cnt;
  logic [31:0] mdl_addr, mdl_data, exp_dmem_addr;
  bit          spur_done = 0, early_done = 0, no_done = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural dmem: done arrives dmem_lat cycles after the issue cycle.
  always @(negedge clk_i) begin
    dmem_done_i    = spur_done;
    dmem_rd_data_i = 32'h0;
    if (reset_i) begin
      mdl_pend = 0;
    end else begin
      if (mdl_pend) begin
        if (mdl_cnt == 0) begin
          check32("dmem_data_stable", dmem_data_o, mdl_data);
          if (!no_done) begin
            dmem_done_i = 1'b1;
            if (mdl_wr) mem[mdl_addr[9:2]] = mdl_data;
            else        dmem_rd_data_i = mem[mdl_addr[9:2]];
          end
          mdl_pend = 0;
        end else begin
          mdl_cnt--;
        end
      end
      if (dmem_read_o || dmem_write_o) begin
        check32("rd_wr_exclusive", {31'h0, dmem_read_o & dmem_write_o}, 32'h0);
        check32("dmem_addr", dmem_addr_o, exp_dmem_addr);
        n_rd += int'(dmem_read_o);
        n_wr += int'(dmem_write_o);
        mdl_pend = 1;
        mdl_cnt  = dmem_lat - 1;
        mdl_addr = dmem_addr_o;
        mdl_data = dmem_data_o;
        mdl_wr   = dmem_write_o;
        if (early_done) begin
          dmem_done_i    = 1'b1;
          dmem_rd_data_i = 32'hA5A5A5A5;
        end
      end
    end
  end

  task automatic send_req(input vec_t v, input logic [TAG_W-1:0] t);
    int n = 0;
    @(negedge clk_i);
    req_valid_i   = 1'b1;
    req_store_i   = v.st;
    req_size_i    = v.size;
    req_signed_i  = v.sgn;
    req_addr_i    = v.addr;
    req_data_i    = v.wdata;
    req_tag_i     = t;
    exp_dmem_addr = {v.addr[31:2], 2'b00};
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check32("req_accept", {31'h0, req_ready_o}, 32'h1);
    sb.push_back('{t, v.exp_data, v.exp_err});
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic get_rsp(input int hold);
    int          n = 0;
    exp_t        e;
    logic [31:0] d0;
    while (!rsp_valid_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check32("rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
    d0 = rsp_data_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check32("hold_data", rsp_data_o, d0);
      check32("hold_valid", {31'h0, rsp_valid_o}, 32'h1);
      check32("hold_ready", {31'h0, req_ready_o}, 32'h0);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: response with empty queue got tag %h expected none", rsp_tag_o);
    end else begin
      e = sb.pop_front();
      if (rsp_tag_o !== e.tag || rsp_data_o !== e.data || rsp_err_o !== e.err) begin
        bad++;
        $display("FAIL rsp: got tag=%h data=%h err=%0d expected tag=%h data=%h err=%0d",
                 rsp_tag_o, rsp_data_o, rsp_err_o, e.tag, e.data, e.err);
      end
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check32("ready_after_rsp", {31'h0, req_ready_o}, 32'h1);
    check32("valid_after_rsp", {31'h0, rsp_valid_o}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input logic [TAG_W-1:0] t, input int hold, input string nm);
    mem[v.addr[9:2]] = v.init;
    n_rd = 0;
    n_wr = 0;
    send_req(v, t);
    get_rsp(hold);
    check32({nm, "_reads"}, n_rd, v.exp_rd);
    check32({nm, "_writes"}, n_wr, v.exp_wr);
    check32({nm, "_mem"}, mem[v.addr[9:2]], v.exp_mem);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    reset_i = 1'b1; req_valid_i = 0; req_store_i = 0; req_size_i = 0; req_signed_i = 0;
    req_addr_i = 0; req_data_i = 0; req_tag_i = 0; rsp_ready_i = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    //          st    size  sgn   addr      wdata         init          exp_data      err   exp_mem       rd wr
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 2'd0, 32'hDEADBEEF, 1, 0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 2'd0, 32'h80FF1234, 1, 0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80FF1234, 32'h00000080, 2'd0, 32'h80FF1234, 1, 0};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0002BEEF, 32'h11223344, 32'h0,        2'd0, 32'hBEEF3344, 1, 1};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        32'hDEADBEEF, 32'h0,        2'd1, 32'hDEADBEEF, 0, 0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h106, 32'h0,        32'h80017FFF, 32'hFFFF8001, 2'd0, 32'h80017FFF, 1, 0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h104, 32'h0,        32'h12348765, 32'h00008765, 2'd0, 32'h12348765, 1, 0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h104, 32'h0,        32'h12348765, 32'hFFFF8765, 2'd0, 32'h12348765, 1, 0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h301, 32'hFFFFFFAB, 32'h11223344, 32'h0,        2'd0, 32'h1122AB44, 1, 1};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h308, 32'hCAFEF00D, 32'h0,        32'h0,        2'd0, 32'hCAFEF00D, 0, 1};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h103, 32'h0,        32'h12345678, 32'h0,        2'd1, 32'h12345678, 0, 0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h10C, 32'h0,        32'h01020304, 32'h01020304, 2'd0, 32'h01020304, 1, 0};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        32'h00008000, 32'hFFFFFF80, 2'd0, 32'h00008000, 1, 0};
    vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h302, 32'h12345678, 32'hAAAAAAAA, 32'h0,        2'd1, 32'hAAAAAAAA, 0, 0};
    vecs[14] = '{1'b1, 2'd0, 1'b0, 32'h310, 32'h00000055, 32'hFFFFFFFF, 32'h0,        2'd0, 32'hFFFFFF55, 1, 1};
    vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h200, 32'h1234ABCD, 32'h11223344, 32'h0,        2'd0, 32'h1122ABCD, 1, 1};
    vecs[16] = '{1'b0, 2'd0, 1'b1, 32'h102, 32'h0,        32'h007F0000, 32'h0000007F, 2'd0, 32'h007F0000, 1, 0};

    repeat (3) @(negedge clk_i);
    check32("rst_ready_in_reset", {31'h0, req_ready_o}, 32'h1);
    reset_i = 1'b0;
    @(negedge clk_i);
    check32("rst_ready", {31'h0, req_ready_o}, 32'h1);
    check32("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check32("rst_pulses", {30'h0, dmem_read_o, dmem_write_o}, 32'h0);
    check32("rst_rsp_data", rsp_data_o, 32'h0);
    check32("rst_rsp_meta", {26'h0, rsp_err_o, rsp_tag_o}, 32'h0);
    check32("rst_dmem_addr", dmem_addr_o, 32'h0);
    check32("rst_dmem_data", dmem_data_o, 32'h0);

    for (int i = 0; i < 17; i++) run_vec(vecs[i], TAG_W'(i), 0, $sformatf("vec%0d", i));

    // Response back-pressure: held five cycles, request side blocked.
    run_vec(vecs[0], 4'hA, 5, "hold");

    // Stray done while idle must not start anything.
    @(posedge clk_i); #1 spur_done = 1;
    @(posedge clk_i); #1 spur_done = 0;
    @(negedge clk_i);
    check32("spur_idle_valid", {31'h0, rsp_valid_o}, 32'h0);
    check32("spur_idle_ready", {31'h0, req_ready_o}, 32'h1);

    // Done coinciding with the issue pulse carries junk and must be ignored.
    dmem_lat = 2; early_done = 1;
    run_vec(vecs[1], 4'hB, 0, "early_done");
    early_done = 0;

    // Slow dmem on a read-modify-write.
    dmem_lat = 4;
    run_vec(vecs[8], 4'hC, 0, "slow_rmw");
    dmem_lat = 1;

    // Async reset in the middle of a wait abandons the request.
    dmem_lat = 20;
    v = vecs[0];
    mem[v.addr[9:2]] = v.init;
    send_req(v, 4'hD);
    repeat (3) @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check32("async_rst_ready", {31'h0, req_ready_o}, 32'h1);
    check32("async_rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    dmem_lat = 1;
    run_vec(vecs[2], 4'hE, 0, "after_rst");

`ifdef DMEM_TIMEOUT_EN
    no_done = 1;
    v = vecs[0];
    v.exp_data = 32'h0;
    v.exp_err  = 2'd2;
    run_vec(v, 4'hF, 0, "timeout");
    no_done = 0;
    run_vec(vecs[3], 4'h3, 0, "post_timeout");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
